// File: rtl/lidar_frame_parser.sv
// Parser for 9-byte TF-Luna style frames arriving from the LiDAR UART receiver.
// Publishes checksum-verified distance/strength/temperature with strobes and counters.
module lidar_frame_parser #(
  parameter logic [7:0]  HEADER_BYTE    = 8'h59,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter logic [15:0] MIN_STRENGTH   = 16'd100
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic [15:0] distance_out,
  output logic [15:0] strength_out,
  output logic [15:0] temp_out,
  output logic        frame_valid_out,
  output logic        reliable_out,
  output logic        chk_err_out,
  output logic [15:0] good_count_out,
  output logic [15:0] err_count_out
);

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_HDR2    = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_CHECK   = 2'd3;

  localparam int unsigned         IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0]   IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDLE_W-1:0]   IDLE_ZERO = {IDLE_W{1'b0}};
  localparam logic [IDLE_W-1:0]   IDLE_ONE  = IDLE_W'(1);

  function automatic logic [7:0] sum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        sum_q, sum_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [15:0]       dist_sh_q, dist_sh_d, str_sh_q, str_sh_d, tmp_sh_q, tmp_sh_d;
  logic [15:0]       distance_q, distance_d, strength_q, strength_d, temp_q, temp_d;
  logic [15:0]       good_cnt_q, good_cnt_d, err_cnt_q, err_cnt_d;
  logic              frame_valid_q, frame_valid_d, chk_err_q, chk_err_d;
  logic              reliable_q, reliable_d;

  // Next-state: byte handling has priority over the idle timeout.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    sum_d         = sum_q;
    idle_d        = idle_q;
    dist_sh_d     = dist_sh_q;
    str_sh_d      = str_sh_q;
    tmp_sh_d      = tmp_sh_q;
    distance_d    = distance_q;
    strength_d    = strength_q;
    temp_d        = temp_q;
    reliable_d    = reliable_q;
    good_cnt_d    = good_cnt_q;
    err_cnt_d     = err_cnt_q;
    frame_valid_d = 1'b0;
    chk_err_d     = 1'b0;
    if (valid_in) begin
      idle_d = IDLE_ZERO;
      case (state_q)
        ST_HUNT: begin
          if (data_in == HEADER_BYTE) state_d = ST_HDR2;
          else                        state_d = ST_HUNT;
        end
        ST_HDR2: begin
          if (data_in == HEADER_BYTE) begin
            state_d = ST_PAYLOAD;
            idx_d   = 3'd2;
            sum_d   = sum_add(HEADER_BYTE, HEADER_BYTE);
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_PAYLOAD: begin
          sum_d = sum_add(sum_q, data_in);
          idx_d = idx_q + 3'd1;
          case (idx_q)
            3'd2:    dist_sh_d[7:0]  = data_in;
            3'd3:    dist_sh_d[15:8] = data_in;
            3'd4:    str_sh_d[7:0]   = data_in;
            3'd5:    str_sh_d[15:8]  = data_in;
            3'd6:    tmp_sh_d[7:0]   = data_in;
            3'd7:    tmp_sh_d[15:8]  = data_in;
            default: dist_sh_d       = dist_sh_q;
          endcase
          if (idx_q == 3'd7) state_d = ST_CHECK;
          else               state_d = ST_PAYLOAD;
        end
        ST_CHECK: begin
          state_d = ST_HUNT;
          if (data_in == sum_q) begin
            distance_d    = dist_sh_q;
            strength_d    = str_sh_q;
            temp_d        = tmp_sh_q;
            reliable_d    = (str_sh_q >= MIN_STRENGTH) && (str_sh_q != 16'hFFFF);
            good_cnt_d    = good_cnt_q + 16'd1;
            frame_valid_d = 1'b1;
          end else begin
            err_cnt_d = err_cnt_q + 16'd1;
            chk_err_d = 1'b1;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end else if (state_q != ST_HUNT) begin
      if (idle_q == IDLE_LAST) begin
        state_d   = ST_HUNT;
        idle_d    = IDLE_ZERO;
        err_cnt_d = err_cnt_q + 16'd1;
      end else begin
        idle_d = idle_q + IDLE_ONE;
      end
    end else begin
      idle_d = IDLE_ZERO;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q       <= ST_HUNT;
      idx_q         <= 3'd0;
      sum_q         <= 8'd0;
      idle_q        <= IDLE_ZERO;
      dist_sh_q     <= 16'd0;
      str_sh_q      <= 16'd0;
      tmp_sh_q      <= 16'd0;
      distance_q    <= 16'd0;
      strength_q    <= 16'd0;
      temp_q        <= 16'd0;
      reliable_q    <= 1'b0;
      good_cnt_q    <= 16'd0;
      err_cnt_q     <= 16'd0;
      frame_valid_q <= 1'b0;
      chk_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      sum_q         <= sum_d;
      idle_q        <= idle_d;
      dist_sh_q     <= dist_sh_d;
      str_sh_q      <= str_sh_d;
      tmp_sh_q      <= tmp_sh_d;
      distance_q    <= distance_d;
      strength_q    <= strength_d;
      temp_q        <= temp_d;
      reliable_q    <= reliable_d;
      good_cnt_q    <= good_cnt_d;
      err_cnt_q     <= err_cnt_d;
      frame_valid_q <= frame_valid_d;
      chk_err_q     <= chk_err_d;
    end
  end

  assign distance_out    = distance_q;
  assign strength_out    = strength_q;
  assign temp_out        = temp_q;
  assign reliable_out    = reliable_q;
  assign good_count_out  = good_cnt_q;
  assign err_count_out   = err_cnt_q;
  assign frame_valid_out = frame_valid_q;
  assign chk_err_out     = chk_err_q;

endmodule

// File: tb/tb_lidar_frame_parser.sv
// Testbench for lidar_frame_parser: directed test-plan steps plus random traffic,
// every cycle compared against a queue-based frame model.
module tb_lidar_frame_parser;

  localparam logic [7:0]  HDR  = 8'h59;
  localparam int          TO   = 50;
  localparam logic [15:0] MINS = 16'd100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        valid = 1'b0;
  logic [15:0] distance, strength, temp, good_cnt, err_cnt;
  logic        fv, rel, ce;

  int checks = 0;
  int errors = 0;

  // reference model state: bytes of the candidate frame collected so far
  logic [7:0]  mbuf[$];
  int          m_idle = 0;
  logic [15:0] m_dist = 16'd0, m_str = 16'd0, m_tmp = 16'd0;
  logic [15:0] m_good = 16'd0, m_err = 16'd0;
  logic        m_rel = 1'b0, m_fv = 1'b0, m_ce = 1'b0;

  lidar_frame_parser #(.HEADER_BYTE(HDR), .TIMEOUT_CYCLES(TO), .MIN_STRENGTH(MINS)) dut (
    .clk_in(clk), .rst_in(rst), .data_in(data), .valid_in(valid),
    .distance_out(distance), .strength_out(strength), .temp_out(temp),
    .frame_valid_out(fv), .reliable_out(rel), .chk_err_out(ce),
    .good_count_out(good_cnt), .err_count_out(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [7:0] d);
    logic [7:0] s;
    m_fv = 1'b0;
    m_ce = 1'b0;
    if (!r) begin
      mbuf.delete();
      m_idle = 0;
      m_dist = 16'd0; m_str = 16'd0; m_tmp = 16'd0;
      m_good = 16'd0; m_err = 16'd0; m_rel = 1'b0;
    end else if (v) begin
      m_idle = 0;
      if (mbuf.size() == 0) begin
        if (d == HDR) mbuf.push_back(d);
      end else if (mbuf.size() == 1) begin
        if (d == HDR) mbuf.push_back(d);
        else mbuf.delete();
      end else begin
        mbuf.push_back(d);
        if (mbuf.size() == 9) begin
          s = 8'h00;
          for (int i = 0; i < 8; i++) s = s + mbuf[i];
          if (s == mbuf[8]) begin
            m_dist = {mbuf[3], mbuf[2]};
            m_str  = {mbuf[5], mbuf[4]};
            m_tmp  = {mbuf[7], mbuf[6]};
            m_rel  = (m_str >= MINS) && (m_str != 16'hFFFF);
            m_good = m_good + 16'd1;
            m_fv   = 1'b1;
          end else begin
            m_err = m_err + 16'd1;
            m_ce  = 1'b1;
          end
          mbuf.delete();
        end
      end
    end else if (mbuf.size() != 0) begin
      m_idle++;
      if (m_idle >= TO) begin
        mbuf.delete();
        m_idle = 0;
        m_err  = m_err + 16'd1;
      end
    end
  endtask

  task automatic compare_all();
    chk("distance", distance, m_dist);
    chk("strength", strength, m_str);
    chk("temp", temp, m_tmp);
    chk("good_count", good_cnt, m_good);
    chk("err_count", err_cnt, m_err);
    chk("reliable", {15'd0, rel}, {15'd0, m_rel});
    chk("frame_valid", {15'd0, fv}, {15'd0, m_fv});
    chk("chk_err", {15'd0, ce}, {15'd0, m_ce});
  endtask

  // one clock: drive at negedge, the posedge samples, outputs checked at next negedge
  task automatic cyc(input logic v, input logic [7:0] d);
    valid = v;
    data  = d;
    @(negedge clk);
    model_step(rst, v, d);
    compare_all();
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'($urandom));
  endtask

  task automatic send_frame(input logic [15:0] dd, input logic [15:0] ss, input logic [15:0] tt,
                            input logic corrupt, input int gap_max);
    logic [7:0] f[9];
    logic [7:0] s;
    f[0] = HDR; f[1] = HDR;
    f[2] = dd[7:0]; f[3] = dd[15:8];
    f[4] = ss[7:0]; f[5] = ss[15:8];
    f[6] = tt[7:0]; f[7] = tt[15:8];
    s = 8'h00;
    for (int i = 0; i < 8; i++) s = s + f[i];
    f[8] = corrupt ? (s ^ 8'h01) : s;
    for (int i = 0; i < 9; i++) begin
      send(f[i]);
      if (gap_max > 0 && i < 8) idle($urandom_range(gap_max, 0));
    end
  endtask

  initial begin
    logic [7:0] good1[9];
    logic [7:0] junk[11];
    logic [7:0] s;
    logic [15:0] rs;
    int kind;

    good1 = '{8'h59, 8'h59, 8'h2C, 8'h01, 8'hE8, 8'h03, 8'h00, 8'h09, 8'hD3};
    junk  = '{8'hAA, 8'h59, 8'h13, 8'h59, 8'h59, 8'h64, 8'h00, 8'h32, 8'h00, 8'h00, 8'h00};

    @(negedge clk);
    rst = 1'b0;
    idle(3);
    chk("reset_distance", distance, 16'd0);
    chk("reset_err", err_cnt, 16'd0);
    rst = 1'b1;
    idle(2000);
    chk("idle_no_err", err_cnt, 16'd0);

    for (int i = 0; i < 9; i++) send(good1[i]);
    chk("f1_pulse", {15'd0, fv}, 16'd1);
    chk("f1_dist", distance, 16'd300);
    chk("f1_str", strength, 16'd1000);
    chk("f1_temp", temp, 16'h0900);
    chk("f1_rel", {15'd0, rel}, 16'd1);
    chk("f1_good", good_cnt, 16'd1);

    // same frame back-to-back with a bad checksum
    for (int i = 0; i < 8; i++) begin
      send(good1[i]);
      if (i == 0) chk("f1_pulse_one_cycle", {15'd0, fv}, 16'd0);
    end
    send(8'hD4);
    chk("bad_chk_pulse", {15'd0, ce}, 16'd1);
    chk("bad_chk_fv", {15'd0, fv}, 16'd0);
    chk("bad_chk_err", err_cnt, 16'd1);
    chk("bad_chk_hold", distance, 16'd300);
    idle(1);
    chk("bad_chk_one_cycle", {15'd0, ce}, 16'd0);

    s = 8'h00;
    for (int i = 3; i < 11; i++) s = s + junk[i];
    for (int i = 0; i < 11; i++) send(junk[i]);
    send(s);
    chk("resync_pulse", {15'd0, fv}, 16'd1);
    chk("resync_dist", distance, 16'd100);
    chk("resync_str", strength, 16'd50);
    chk("resync_rel", {15'd0, rel}, 16'd0);

    send(HDR); send(HDR); send(8'h2C);
    idle(TO - 1);
    chk("timeout_not_yet", err_cnt, 16'd1);
    idle(1);
    chk("timeout_err", err_cnt, 16'd2);
    send_frame(16'd1234, 16'd500, 16'd77, 1'b0, 0);
    chk("after_timeout_dist", distance, 16'd1234);
    chk("after_timeout_good", good_cnt, 16'd3);

    // a gap one short of the timeout between every byte still parses
    for (int i = 0; i < 9; i++) begin
      send(good1[i]);
      if (i < 8) idle(TO - 1);
    end
    chk("max_gap_good", good_cnt, 16'd4);
    chk("max_gap_err", err_cnt, 16'd2);

    for (int i = 0; i < 5; i++) send(good1[i]);
    rst = 1'b0;
    send(HDR);
    rst = 1'b1;
    chk("rst_mid_good", good_cnt, 16'd0);
    for (int i = 5; i < 9; i++) send(good1[i]);
    send_frame(16'd42, 16'hFFFF, 16'd3, 1'b0, 0);
    chk("rst_mid_after_good", good_cnt, 16'd1);
    chk("rst_mid_sat_rel", {15'd0, rel}, 16'd0);

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(5, 0);
      case (kind)
        0, 1: begin
          rs = ($urandom_range(3, 0) == 0) ? 16'($urandom_range(102, 98)) : 16'($urandom);
          send_frame(16'($urandom), rs, 16'($urandom), 1'b0, $urandom_range(2, 0));
        end
        2: send_frame(16'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1);
        3: begin
          for (int i = 0; i < int'($urandom_range(6, 1)); i++)
            send(($urandom_range(2, 0) == 0) ? HDR : 8'($urandom));
        end
        4: begin
          send(HDR); send(HDR);
          idle($urandom_range(TO + 2, TO - 2));
        end
        default: idle($urandom_range(TO + 5, 0));
      endcase
    end
    idle(TO + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
